// File: rtl/button_conditioner_pkg.sv
// Shared state encoding and default timing constants for the button conditioner.
package button_conditioner_pkg;

   localparam int unsigned CLK_HZ_DEFAULT          = 12_000_000;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = CLK_HZ_DEFAULT / 100;  // 10 ms
   localparam int unsigned HOLD_CYCLES_DEFAULT     = CLK_HZ_DEFAULT;        // 1 s

   typedef enum logic [1:0] {
      IDLE_LOW,
      CHECK_HIGH,
      IDLE_HIGH,
      CHECK_LOW
   } debounce_state_e;

endpackage

// File: rtl/button_conditioner_debounce_bit.sv
// Single-bit debouncer: qualifies a synchronized level and emits stable/press/release,
// plus a long-press level when BUTTON_CONDITIONER_HOLD_EN is defined.
module debounce_bit
   import button_conditioner_pkg::*;
#(
   parameter int unsigned debounce_cycles_p = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned hold_cycles_p     = HOLD_CYCLES_DEFAULT
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic sync_i,
   output logic stable_o,
   output logic press_o,
   output logic release_o,
   output logic hold_o
);

   localparam int unsigned      CntW    = $clog2(debounce_cycles_p + 1);
   localparam logic [CntW-1:0]  CntLast = CntW'(debounce_cycles_p - 1);
   localparam logic [CntW-1:0]  CntOne  = CntW'(1);

   if ((debounce_cycles_p == 0) || (hold_cycles_p == 0)) begin : g_bad_params
      $error("debounce_bit: debounce_cycles_p and hold_cycles_p must be >= 1");
   end

   debounce_state_e  r_state;
   logic [CntW-1:0]  r_count;
   logic             r_stable;
   logic             r_press;
   logic             r_release;

   // The first differing sample already counts, so acceptance lands exactly
   // debounce_cycles_p cycles after the synced change.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state   <= IDLE_LOW;
         r_count   <= '0;
         r_stable  <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         case (r_state)
            IDLE_LOW: begin
               if (sync_i) begin
                  if (debounce_cycles_p == 1) begin
                     r_state  <= IDLE_HIGH;
                     r_stable <= 1'b1;
                     r_press  <= 1'b1;
                  end else begin
                     r_state <= CHECK_HIGH;
                     r_count <= CntOne;
                  end
               end
            end
            CHECK_HIGH: begin
               if (!sync_i) begin
                  r_state <= IDLE_LOW;
                  r_count <= '0;
               end else if (r_count == CntLast) begin
                  r_state  <= IDLE_HIGH;
                  r_count  <= '0;
                  r_stable <= 1'b1;
                  r_press  <= 1'b1;
               end else begin
                  r_count <= r_count + CntOne;
               end
            end
            IDLE_HIGH: begin
               if (!sync_i) begin
                  if (debounce_cycles_p == 1) begin
                     r_state   <= IDLE_LOW;
                     r_stable  <= 1'b0;
                     r_release <= 1'b1;
                  end else begin
                     r_state <= CHECK_LOW;
                     r_count <= CntOne;
                  end
               end
            end
            CHECK_LOW: begin
               if (sync_i) begin
                  r_state <= IDLE_HIGH;
                  r_count <= '0;
               end else if (r_count == CntLast) begin
                  r_state   <= IDLE_LOW;
                  r_count   <= '0;
                  r_stable  <= 1'b0;
                  r_release <= 1'b1;
               end else begin
                  r_count <= r_count + CntOne;
               end
            end
            default: begin
               r_state <= IDLE_LOW;
               r_count <= '0;
            end
         endcase
      end
   end

   assign stable_o  = r_stable;
   assign press_o   = r_press;
   assign release_o = r_release;

`ifdef BUTTON_CONDITIONER_HOLD_EN
   localparam int unsigned       HoldW    = $clog2(hold_cycles_p + 1);
   localparam logic [HoldW-1:0]  HoldMax  = HoldW'(hold_cycles_p);
   localparam logic [HoldW-1:0]  HoldLast = HoldW'(hold_cycles_p - 1);

   logic              w_accept_fall;
   logic [HoldW-1:0]  r_hold_count;
   logic              r_hold;

   // Same condition that drops r_stable, so hold_o falls together with release_o.
   assign w_accept_fall = !sync_i &&
                          (((r_state == CHECK_LOW) && (r_count == CntLast)) ||
                           ((r_state == IDLE_HIGH) && (debounce_cycles_p == 1)));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_hold_count <= '0;
         r_hold       <= 1'b0;
      end else if (!r_stable || w_accept_fall) begin
         r_hold_count <= '0;
         r_hold       <= 1'b0;
      end else if (r_hold_count != HoldMax) begin
         r_hold_count <= r_hold_count + HoldW'(1);
         if (r_hold_count == HoldLast) begin
            r_hold <= 1'b1;
         end
      end
   end

   assign hold_o = r_hold;
`else
   assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw button pins into synchronized, debounced levels and press/release pulses.
// Optional long-press output enabled by defining BUTTON_CONDITIONER_HOLD_EN.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned width_p           = 3,
   parameter int unsigned sync_stages_p     = 2,
   parameter int unsigned debounce_cycles_p = DEBOUNCE_CYCLES_DEFAULT,
   parameter bit          invert_p          = 1'b0,
   parameter int unsigned hold_cycles_p     = HOLD_CYCLES_DEFAULT
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] btn_async_unsafe_i,
   output logic [width_p-1:0] btn_o,
   output logic [width_p-1:0] press_o,
   output logic [width_p-1:0] release_o,
   output logic [width_p-1:0] hold_o
);

   if (sync_stages_p < 2) begin : g_bad_sync
      $error("button_conditioner: sync_stages_p must be >= 2");
   end

   logic [width_p-1:0] w_raw;
   logic [width_p-1:0] r_sync [sync_stages_p];

   assign w_raw = invert_p ? ~btn_async_unsafe_i : btn_async_unsafe_i;

   // Plain flop chain per bit; nothing between stages.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < sync_stages_p; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= w_raw;
         for (int unsigned i = 1; i < sync_stages_p; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   for (genvar g = 0; g < width_p; g++) begin : g_bit
      debounce_bit #(
         .debounce_cycles_p (debounce_cycles_p),
         .hold_cycles_p     (hold_cycles_p)
      ) u_debounce_bit (
         .clk_i     (clk_i),
         .reset_i   (reset_i),
         .sync_i    (r_sync[sync_stages_p-1][g]),
         .stable_o  (btn_o[g]),
         .press_o   (press_o[g]),
         .release_o (release_o[g]),
         .hold_o    (hold_o[g])
      );
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side counterpart to the LED output path: takes raw, asynchronous, bouncing icebreaker buttons and produces clean, clock-synchronous levels plus one-cycle press/release pulses for downstream logic.
- Sits between the top-level button pins and any consumer logic, such as counters, FSMs or LED drivers.
- Each bit is conditioned independently.

Parameters:
- width_p, 3, number of button bits conditioned.
- sync_stages_p, 2, flip-flop synchronizer depth (legal values ≥2).
- debounce_cycles_p, 120000, number of consecutive cycles a changed input must hold before it is accepted (10 ms at 12 MHz; ≥1).
- invert_p, 0, 1 = raw input is active-low; it is inverted before the synchronizer.
- hold_cycles_p, 12000000, long-press threshold in cycles; used only with the optional feature.

Ports:
- clk_i, input, 1, system clock (12 MHz on icebreaker).
- reset_i, input, 1, asynchronous active-high reset.
- btn_async_unsafe_i, input, width_p, raw button pins; not synchronized, not debounced.
- btn_o, output, width_p, debounced level; 1 = pressed.
- press_o, output, width_p, one-cycle pulse on accepted 0→1.
- release_o, output, width_p, one-cycle pulse on accepted 1→0.
- hold_o, output, width_p, long-press level (optional feature; otherwise constant 0).

Behaviour:
- Reset (async assert; release takes effect at the next edge): synchronizer flops, stable state, counters, btn_o, press_o, release_o and hold_o all go to 0 ("released").
- Polarity: with invert_p=1 the raw bit is inverted before stage 1, so an idle active-low pin reads released.
- Synchronizer: sync_stages_p flops in series per bit. No logic sits between stages.
- Per-bit FSM states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW.
  - IDLE_LOW → CHECK_HIGH when synced=1.
  - CHECK_HIGH → IDLE_LOW when synced=0 (bounce: counter cleared).
  - CHECK_HIGH → IDLE_HIGH when synced=1 and count==debounce_cycles_p-1.
  - IDLE_HIGH, CHECK_LOW and the transition back to IDLE_LOW are symmetric.
- Counter:
  - Width $clog2(debounce_cycles_p+1).
  - Increments each edge while in a CHECK state and synced differs from the stable value.
  - Clears on a bounce or on acceptance; never wraps.
- Latency: a clean raw change is reflected on btn_o exactly sync_stages_p+debounce_cycles_p cycles later. With invert_p=0, sync_stages_p=2, debounce_cycles_p=4: raw set before edge 1 → btn_o=1 after edge 6.
- Pulses:
  - press_o/release_o are registered. They assert on the same edge btn_o changes and last exactly one cycle.
  - Press and release of the same bit can never coincide.
  - Different bits are fully independent and may pulse simultaneously.
- Bounce: any raw glitch shorter than debounce_cycles_p synced cycles produces no change on btn_o and no pulse.
- Reset mid-count: all state is discarded. After reset deasserts, a held button is re-qualified from IDLE_LOW and needs the full latency again.

Optional Feature:
- Macro: BUTTON_CONDITIONER_HOLD_EN.
- Defined:
  - Per-bit saturating hold counter, width $clog2(hold_cycles_p+1).
  - Counts each cycle btn_o=1 and clears when btn_o=0.
  - hold_o asserts on the edge the count reaches hold_cycles_p.
  - hold_o stays high until the edge btn_o falls; it deasserts on that same edge, concurrent with release_o.
- Undefined: no hold counter is instantiated; hold_o is tied to 0. The port list is identical in both builds.

Decomposition:
- Package button_conditioner_pkg:
  - State enum debounce_state_e: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW.
  - Default constants: debounce 10 ms at 12 MHz, hold 1 s.
- Sub-module debounce_bit: one synchronized bit in; stable, press, release (and hold when enabled) out. Contains the FSM and counters.
- The top generates width_p instances of debounce_bit behind a shared synchronizer array.

Test Plan (sync_stages_p=2, debounce_cycles_p=4, hold_cycles_p=8, width_p=3):
- Reset check: hold reset_i high with raw=3'b111, then deassert → all outputs 0 on the first cycle after deassert.
- Clean press: raw[0] 0→1 before edge 1 and held → btn_o[0]=1 and press_o[0]=1 after edge 6; press_o[0] drops after edge 7.
- Bounce: raw[1] toggles 1,0,1,0 on successive cycles, then stays 0 → btn_o[1], press_o[1] and release_o[1] remain 0 throughout.
- Release with invert_p=1: raw[2] driven 0 (pressed) until btn_o[2]=1, then driven 1 → release_o[2] pulses for one cycle exactly 6 cycles after the raw edge.
- Reset mid-count: assert reset_i after edge 4 of a clean press, release it, keep raw high → btn_o stays 0 until 6 cycles after reset release.
- Long press (HOLD_EN defined): keep raw[0] high → hold_o[0] rises 8 cycles after btn_o[0] rises. On raw release, hold_o[0] falls on the same edge release_o[0] pulses. With the macro undefined, hold_o stays 0.
